// File: rtl/level_controller.sv
// Game-flow FSM: countdown timer, hit-driven level/speed progression, game enable.
// Optional bonus time on level-up is enabled by defining LEVEL_CTRL_BONUS_TIME_EN.
module level_controller #(
    parameter int unsigned TICKS_PER_SEC  = 50_000_000,
    parameter int unsigned GAME_SECONDS   = 60,
    parameter int unsigned HITS_PER_LEVEL = 5,
    parameter int unsigned LEVELS         = 4,
    parameter int unsigned BASE_SPEED     = 99_999_999,
    parameter int unsigned SPEED_STEP     = 20_000_000,
    parameter int unsigned MIN_SPEED      = 25_000_000,
    parameter int unsigned BONUS_SECONDS  = 10
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        hit,
    output logic        game,
    output logic [27:0] speed,
    output logic [2:0]  level,
    output logic [7:0]  time_left,
    output logic        game_over
);

    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int HW = (HITS_PER_LEVEL > 1) ? $clog2(HITS_PER_LEVEL) : 1;

`ifdef LEVEL_CTRL_BONUS_TIME_EN
    localparam bit BONUS_EN = 1'b1;
`else
    localparam bit BONUS_EN = 1'b0;
`endif

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PLAY  = 2'd1;
    localparam logic [1:0] S_LVLUP = 2'd2;
    localparam logic [1:0] S_OVER  = 2'd3;

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);
    localparam logic [HW-1:0] HIT_LAST   = HW'(HITS_PER_LEVEL - 1);
    localparam logic [2:0]    LVL_TOP    = 3'(LEVELS - 1);

    logic [1:0]    state_q, state_d;
    logic          start_d_q, start_d_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [HW-1:0] hit_cnt_q, hit_cnt_d;
    logic [2:0]    level_q, level_d;
    logic [27:0]   speed_q, speed_d;
    logic [7:0]    time_q, time_d;
    logic          game_q, game_d;
    logic          over_q, over_d;

    logic          start_rise;
    logic          wrap;
    logic          active_q;
    logic          active_d;
    logic [2:0]    lvl_nxt;
    logic [63:0]   step_prod;
    logic [31:0]   bonus_sum;

    assign start_rise = start & ~start_d_q;
    assign wrap       = (presc_q == PRESC_LAST);
    assign lvl_nxt    = (level_q == LVL_TOP) ? level_q : level_q + 3'd1;
    assign step_prod  = 64'(lvl_nxt) * 64'(SPEED_STEP);

    always_comb begin
        state_d   = state_q;
        start_d_d = start;
        presc_d   = presc_q;
        hit_cnt_d = hit_cnt_q;
        level_d   = level_q;
        speed_d   = speed_q;
        time_d    = time_q;
        bonus_sum = 32'd0;

        case (state_q)
            S_PLAY, S_LVLUP: begin
                if (!start) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_PLAY;
                    presc_d = wrap ? '0 : presc_q + PW'(1);
                    // Commit the level-up decided on the previous cycle
                    if (state_q == S_LVLUP && level_q != LVL_TOP) begin
                        level_d = lvl_nxt;
                        if (64'(BASE_SPEED) < step_prod + 64'(MIN_SPEED))
                            speed_d = 28'(MIN_SPEED);
                        else
                            speed_d = 28'(64'(BASE_SPEED) - step_prod);
                    end
                    if (wrap)
                        time_d = time_q - 8'd1;
                    if (wrap && time_q == 8'd1) begin
                        state_d = S_OVER;
                        time_d  = 8'd0;
                    end else if (hit) begin
                        if (hit_cnt_q == HIT_LAST) begin
                            hit_cnt_d = '0;
                            state_d   = S_LVLUP;
                            if (BONUS_EN && level_q != LVL_TOP) begin
                                bonus_sum = 32'(time_d) + BONUS_SECONDS;
                                time_d = (bonus_sum > 32'd255) ? 8'd255
                                                               : bonus_sum[7:0];
                            end
                        end else begin
                            hit_cnt_d = hit_cnt_q + HW'(1);
                        end
                    end
                end
            end
            default: begin
                if (state_q == S_OVER && !start) begin
                    state_d = S_IDLE;
                end else if (start_rise) begin
                    state_d   = S_PLAY;
                    level_d   = 3'd0;
                    speed_d   = 28'(BASE_SPEED);
                    time_d    = 8'(GAME_SECONDS);
                    presc_d   = '0;
                    hit_cnt_d = '0;
                end
            end
        endcase
    end

    // game needs a cycle in an active state before rising, but drops at once
    assign active_q = (state_q == S_PLAY) || (state_q == S_LVLUP);
    assign active_d = (state_d == S_PLAY) || (state_d == S_LVLUP);

    always_comb begin
        game_d = active_q && active_d;
        over_d = (state_d == S_OVER);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            start_d_q <= 1'b0;
            presc_q   <= '0;
            hit_cnt_q <= '0;
            level_q   <= 3'd0;
            speed_q   <= 28'(BASE_SPEED);
            time_q    <= 8'(GAME_SECONDS);
            game_q    <= 1'b0;
            over_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            start_d_q <= start_d_d;
            presc_q   <= presc_d;
            hit_cnt_q <= hit_cnt_d;
            level_q   <= level_d;
            speed_q   <= speed_d;
            time_q    <= time_d;
            game_q    <= game_d;
            over_q    <= over_d;
        end
    end

    assign game      = game_q;
    assign speed     = speed_q;
    assign level     = level_q;
    assign time_left = time_q;
    assign game_over = over_q;

endmodule

// File: tb/tb_level_controller.sv
// Scoreboard bench for level_controller with small timing parameters.
// Expected output words are queued with each driven step and popped after the edge.
module tb_level_controller;

`ifdef LEVEL_CTRL_BONUS_TIME_EN
    localparam int BON = 1;
`else
    localparam int BON = 0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        hit = 1'b0;
    logic        game;
    logic [27:0] speed;
    logic [2:0]  level;
    logic [7:0]  time_left;
    logic        game_over;

    int n_cmp = 0;
    int n_bad = 0;

    logic [40:0] sb[$];
    logic [40:0] got;
    logic [40:0] e;

    typedef struct {
        bit          rst;
        bit          st;
        bit          hit;
        bit          chk;
        logic [40:0] exp;
    } step_t;

    always #5 clk = ~clk;

    level_controller #(
        .TICKS_PER_SEC (4),
        .GAME_SECONDS  (3),
        .HITS_PER_LEVEL(2),
        .LEVELS        (3),
        .BASE_SPEED    (100),
        .SPEED_STEP    (30),
        .MIN_SPEED     (50),
        .BONUS_SECONDS (2)
    ) dut (
        .clock    (clk),
        .reset    (reset),
        .start    (start),
        .hit      (hit),
        .game     (game),
        .speed    (speed),
        .level    (level),
        .time_left(time_left),
        .game_over(game_over)
    );

    // word layout: {game, game_over, level, speed, time_left}
    function automatic logic [40:0] mk(bit g, bit o, int l, int spd, int t);
        return {g, o, 3'(l), 28'(spd), 8'(t)};
    endfunction

    function automatic step_t sp(bit r, bit s, bit h);
        step_t x;
        x.rst = r; x.st = s; x.hit = h; x.chk = 1'b0; x.exp = '0;
        return x;
    endfunction

    function automatic step_t sc(bit r, bit s, bit h, logic [40:0] ex);
        step_t x;
        x.rst = r; x.st = s; x.hit = h; x.chk = 1'b1; x.exp = ex;
        return x;
    endfunction

    task automatic test_reset();
        step_t s[$];
        s.push_back(sp(1, 0, 0));
        s.push_back(sc(1, 0, 0, mk(0, 0, 0, 100, 3)));
        s.push_back(sc(0, 0, 0, mk(0, 0, 0, 100, 3)));
        foreach (s[i]) begin
            reset = s[i].rst; start = s[i].st; hit = s[i].hit;
            if (s[i].chk) sb.push_back(s[i].exp);
            @(posedge clk); #1;
            if (s[i].chk) begin
                e = sb.pop_front();
                got = {game, game_over, level, speed, time_left};
                n_cmp++;
                if (got !== e) begin
                    n_bad++;
                    $display("FAIL reset step %0d: got %h want %h", i, got, e);
                end
            end
        end
    endtask

    task automatic test_timeout();
        step_t s[$];
        for (int n = 1; n <= 13; n++)
            s.push_back(sc(0, 1, 0,
                mk(n >= 2 && n < 13, n == 13, 0, 100, 3 - (n - 1) / 4)));
        s.push_back(sc(0, 1, 0, mk(0, 1, 0, 100, 0)));
        s.push_back(sc(0, 0, 0, mk(0, 0, 0, 100, 0)));
        foreach (s[i]) begin
            reset = s[i].rst; start = s[i].st; hit = s[i].hit;
            if (s[i].chk) sb.push_back(s[i].exp);
            @(posedge clk); #1;
            if (s[i].chk) begin
                e = sb.pop_front();
                got = {game, game_over, level, speed, time_left};
                n_cmp++;
                if (got !== e) begin
                    n_bad++;
                    $display("FAIL timeout step %0d: got %h want %h", i, got, e);
                end
            end
        end
    endtask

    task automatic test_levels();
        step_t s[$];
        s.push_back(sc(0, 1, 0, mk(0, 0, 0, 100, 3)));
        s.push_back(sc(0, 1, 0, mk(1, 0, 0, 100, 3)));
        s.push_back(sp(0, 1, 1));
        s.push_back(sc(0, 1, 1, mk(1, 0, 0, 100, BON ? 5 : 3)));
        s.push_back(sc(0, 1, 0, mk(1, 0, 1, 70, BON ? 4 : 2)));
        s.push_back(sp(0, 1, 1));
        s.push_back(sp(0, 1, 1));
        s.push_back(sc(0, 1, 0, mk(1, 0, 2, 50, BON ? 6 : 2)));
        s.push_back(sp(0, 1, 1));
        s.push_back(sp(0, 1, 1));
        s.push_back(sc(0, 1, 0, mk(1, 0, 2, 50, BON ? 5 : 1)));
        s.push_back(sp(0, 1, 0));
        s.push_back(sc(0, 1, 0, BON ? mk(1, 0, 2, 50, 4) : mk(0, 1, 2, 50, 0)));
        s.push_back(sc(0, 0, 0, mk(0, 0, 2, 50, BON ? 4 : 0)));
        foreach (s[i]) begin
            reset = s[i].rst; start = s[i].st; hit = s[i].hit;
            if (s[i].chk) sb.push_back(s[i].exp);
            @(posedge clk); #1;
            if (s[i].chk) begin
                e = sb.pop_front();
                got = {game, game_over, level, speed, time_left};
                n_cmp++;
                if (got !== e) begin
                    n_bad++;
                    $display("FAIL levels step %0d: got %h want %h", i, got, e);
                end
            end
        end
    endtask

    task automatic test_expiry_hit();
        step_t s[$];
        s.push_back(sc(0, 1, 0, mk(0, 0, 0, 100, 3)));
        for (int n = 2; n <= 11; n++)
            s.push_back(sp(0, 1, 0));
        s.push_back(sp(0, 1, 1));
        s.push_back(sc(0, 1, 1, mk(0, 1, 0, 100, 0)));
        s.push_back(sc(0, 1, 0, mk(0, 1, 0, 100, 0)));
        s.push_back(sc(0, 0, 0, mk(0, 0, 0, 100, 0)));
        foreach (s[i]) begin
            reset = s[i].rst; start = s[i].st; hit = s[i].hit;
            if (s[i].chk) sb.push_back(s[i].exp);
            @(posedge clk); #1;
            if (s[i].chk) begin
                e = sb.pop_front();
                got = {game, game_over, level, speed, time_left};
                n_cmp++;
                if (got !== e) begin
                    n_bad++;
                    $display("FAIL expiry_hit step %0d: got %h want %h", i, got, e);
                end
            end
        end
    endtask

    task automatic test_abort();
        step_t s[$];
        s.push_back(sp(0, 1, 0));
        s.push_back(sp(0, 1, 0));
        s.push_back(sp(0, 1, 1));
        s.push_back(sp(0, 1, 1));
        s.push_back(sc(0, 1, 0, mk(1, 0, 1, 70, BON ? 4 : 2)));
        s.push_back(sc(0, 0, 0, mk(0, 0, 1, 70, BON ? 4 : 2)));
        s.push_back(sc(0, 1, 0, mk(0, 0, 0, 100, 3)));
        s.push_back(sc(0, 1, 0, mk(1, 0, 0, 100, 3)));
        foreach (s[i]) begin
            reset = s[i].rst; start = s[i].st; hit = s[i].hit;
            if (s[i].chk) sb.push_back(s[i].exp);
            @(posedge clk); #1;
            if (s[i].chk) begin
                e = sb.pop_front();
                got = {game, game_over, level, speed, time_left};
                n_cmp++;
                if (got !== e) begin
                    n_bad++;
                    $display("FAIL abort step %0d: got %h want %h", i, got, e);
                end
            end
        end
    endtask

    // continues the game left running by test_abort
    task automatic test_bonus();
        step_t s[$];
        s.push_back(sp(0, 1, 0));
        s.push_back(sp(0, 1, 0));
        s.push_back(sc(0, 1, 0, mk(1, 0, 0, 100, 2)));
        s.push_back(sp(0, 1, 1));
        s.push_back(sc(0, 1, 1, mk(1, 0, 0, 100, BON ? 4 : 2)));
        s.push_back(sc(0, 1, 0, mk(1, 0, 1, 70, BON ? 4 : 2)));
        s.push_back(sc(0, 0, 0, mk(0, 0, 1, 70, BON ? 4 : 2)));
        foreach (s[i]) begin
            reset = s[i].rst; start = s[i].st; hit = s[i].hit;
            if (s[i].chk) sb.push_back(s[i].exp);
            @(posedge clk); #1;
            if (s[i].chk) begin
                e = sb.pop_front();
                got = {game, game_over, level, speed, time_left};
                n_cmp++;
                if (got !== e) begin
                    n_bad++;
                    $display("FAIL bonus step %0d: got %h want %h", i, got, e);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_timeout();
        test_levels();
        test_expiry_hit();
        test_abort();
        test_bonus();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
